// File: rtl/deck_dealer.sv
// Captures a shuffled 52-card stream, rejecting out-of-range/duplicate codes, then deals one card per request.
// Deal latency 1 cycle; no backpressure, dealReq is honoured every cycle while READY and ignored otherwise.
module deck_dealer #(
  parameter int DECK_SIZE = 52,
  parameter int CARD_W    = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              loadFlag,
  input  logic [CARD_W-1:0] card,
  input  logic              newDeck,
  input  logic              dealReq,
  output logic [CARD_W-1:0] dealtCard,
  output logic [3:0]        dealtRank,
  output logic [3:0]        dealtPoints,
  output logic              dealValid,
  output logic              deckReady,
  output logic              deckEmpty,
  output logic [5:0]        cardCount,
  output logic              loadErr
);

  typedef enum logic [1:0] {LOAD, READY, EMPTY} state_t;

  localparam logic [CARD_W-1:0] LAST_IDX = CARD_W'(DECK_SIZE - 1);

  state_t                state_q, state_d;
  logic [CARD_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CARD_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [DECK_SIZE-1:0]  seen_q, seen_d;
  logic                  load_err_q, load_err_d;
  logic [CARD_W-1:0]     dealt_card_q, dealt_card_d;
  logic [3:0]            dealt_rank_q, dealt_rank_d;
  logic [3:0]            dealt_points_q, dealt_points_d;
  logic                  deal_valid_q, deal_valid_d;
  logic                  deck_ready_q, deck_ready_d;
  logic                  deck_empty_q, deck_empty_d;
  logic [CARD_W-1:0]     mem_q [DECK_SIZE];
  logic                  mem_we;
  logic                  card_ok;
  logic [CARD_W-1:0]     deal_code;

  // Code % 13 by at most one subtraction of a multiple of 13; rank is 1-based.
  function automatic logic [3:0] rank_of(input logic [CARD_W-1:0] c);
    logic [CARD_W-1:0] r;
    r = c;
    if (r >= CARD_W'(39))      r = r - CARD_W'(39);
    else if (r >= CARD_W'(26)) r = r - CARD_W'(26);
    else if (r >= CARD_W'(13)) r = r - CARD_W'(13);
    return 4'(r) + 4'd1;
  endfunction

  assign card_ok   = (card <= LAST_IDX) && !seen_q[card];
  assign deal_code = mem_q[rd_ptr_q];

  always_comb begin
    state_d        = state_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    seen_d         = seen_q;
    load_err_d     = load_err_q;
    dealt_card_d   = dealt_card_q;
    dealt_rank_d   = dealt_rank_q;
    dealt_points_d = dealt_points_q;
    deal_valid_d   = 1'b0;
    deck_ready_d   = deck_ready_q;
    deck_empty_d   = deck_empty_q;
    mem_we         = 1'b0;
    if (newDeck) begin
      state_d      = LOAD;
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      seen_d       = '0;
      load_err_d   = 1'b0;
      deck_ready_d = 1'b0;
      deck_empty_d = 1'b0;
    end else begin
      case (state_q)
        LOAD: begin
          if (loadFlag) begin
            if (card_ok) begin
              mem_we       = 1'b1;
              seen_d[card] = 1'b1;
              wr_ptr_d     = wr_ptr_q + CARD_W'(1);
              if (wr_ptr_q == LAST_IDX) begin
                state_d      = READY;
                deck_ready_d = 1'b1;
              end
            end else begin
              load_err_d = 1'b1;
            end
          end
        end
        READY: begin
          if (dealReq) begin
            dealt_card_d   = deal_code;
            dealt_rank_d   = rank_of(deal_code);
            dealt_points_d = (rank_of(deal_code) > 4'd10) ? 4'd10 : rank_of(deal_code);
            deal_valid_d   = 1'b1;
            rd_ptr_d       = rd_ptr_q + CARD_W'(1);
            if (rd_ptr_q == LAST_IDX) begin
              state_d      = EMPTY;
              deck_ready_d = 1'b0;
              deck_empty_d = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= LOAD;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      seen_q         <= '0;
      load_err_q     <= 1'b0;
      dealt_card_q   <= '0;
      dealt_rank_q   <= '0;
      dealt_points_q <= '0;
      deal_valid_q   <= 1'b0;
      deck_ready_q   <= 1'b0;
      deck_empty_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      seen_q         <= seen_d;
      load_err_q     <= load_err_d;
      dealt_card_q   <= dealt_card_d;
      dealt_rank_q   <= dealt_rank_d;
      dealt_points_q <= dealt_points_d;
      deal_valid_q   <= deal_valid_d;
      deck_ready_q   <= deck_ready_d;
      deck_empty_q   <= deck_empty_d;
    end
  end

  // Deck contents are only meaningful behind wrPtr, so the store needs no reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wr_ptr_q] <= card;
  end

  assign dealtCard   = dealt_card_q;
  assign dealtRank   = dealt_rank_q;
  assign dealtPoints = dealt_points_q;
  assign dealValid   = deal_valid_q;
  assign deckReady   = deck_ready_q;
  assign deckEmpty   = deck_empty_q;
  assign cardCount   = 6'(wr_ptr_q - rd_ptr_q);
  assign loadErr     = load_err_q;

endmodule

// File: tb/tb_deck_dealer.sv
// Bench for deck_dealer: queue-based deck model compared every cycle, plus directed literal checks.
module tb_deck_dealer;
  localparam int N = 52;

  logic       clk = 1'b0, rst = 1'b0;
  logic       loadFlag = 1'b0, newDeck = 1'b0, dealReq = 1'b0;
  logic [5:0] card = '0;
  logic [5:0] dealtCard, cardCount;
  logic [3:0] dealtRank, dealtPoints;
  logic       dealValid, deckReady, deckEmpty, loadErr;

  deck_dealer #(.DECK_SIZE(N), .CARD_W(6)) dut (
    .clk(clk), .rst(rst), .loadFlag(loadFlag), .card(card), .newDeck(newDeck),
    .dealReq(dealReq), .dealtCard(dealtCard), .dealtRank(dealtRank),
    .dealtPoints(dealtPoints), .dealValid(dealValid), .deckReady(deckReady),
    .deckEmpty(deckEmpty), .cardCount(cardCount), .loadErr(loadErr)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_pass = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0d want %0d", name, got, want);
  endtask

  // Model: the deck is the queue of accepted codes; dealing walks through it.
  int m_deck[$];
  bit m_seen[N];
  int m_dealt;
  bit m_err, m_valid;
  int m_card, m_rank, m_pts;

  function automatic void m_reset();
    m_deck.delete();
    foreach (m_seen[i]) m_seen[i] = 1'b0;
    m_dealt = 0; m_err = 0; m_valid = 0;
    m_card = 0; m_rank = 0; m_pts = 0;
  endfunction

  function automatic void m_step();
    int c;
    c = int'(card);
    m_valid = 0;
    if (newDeck) begin
      m_deck.delete();
      foreach (m_seen[i]) m_seen[i] = 1'b0;
      m_dealt = 0; m_err = 0;
    end else if (m_deck.size() < N) begin
      if (loadFlag) begin
        if (c < N && !m_seen[c]) begin
          m_deck.push_back(c);
          m_seen[c] = 1'b1;
        end else m_err = 1;
      end
    end else if (m_dealt < N && dealReq) begin
      m_card  = m_deck[m_dealt];
      m_rank  = m_card % 13 + 1;
      m_pts   = (m_rank > 10) ? 10 : m_rank;
      m_valid = 1;
      m_dealt++;
    end
  endfunction

  bit chk_en = 0;

  always @(posedge clk) begin
    if (rst) m_step();
    #1;
    if (chk_en) begin
      check("dealValid",   dealValid,   m_valid);
      check("dealtCard",   dealtCard,   m_card);
      check("dealtRank",   dealtRank,   m_rank);
      check("dealtPoints", dealtPoints, m_pts);
      check("deckReady",   deckReady,   (m_deck.size() == N && m_dealt < N));
      check("deckEmpty",   deckEmpty,   (m_dealt == N));
      check("cardCount",   cardCount,   m_deck.size() - m_dealt);
      check("loadErr",     loadErr,     m_err);
    end
  end

  task automatic step(input bit lf, input int c, input bit nd, input bit dr);
    @(negedge clk);
    loadFlag = lf; card = 6'(c); newDeck = nd; dealReq = dr;
    @(posedge clk);
    #2;
  endtask

  int perm[N];

  task automatic make_perm();
    int j, t;
    for (int i = 0; i < N; i++) perm[i] = i;
    for (int i = N - 1; i > 0; i--) begin
      j = $urandom_range(0, i);
      t = perm[i]; perm[i] = perm[j]; perm[j] = t;
    end
  endtask

  task automatic load_perm(input int gap_max);
    make_perm();
    for (int i = 0; i < N; i++) begin
      step(1, perm[i], 0, 0);
      repeat ($urandom_range(0, gap_max)) step(0, int'($urandom % 64), 0, 0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_dealValid"}, dealValid, 0);
    check({tag, "_dealtCard"}, dealtCard, 0);
    check({tag, "_dealtRank"}, dealtRank, 0);
    check({tag, "_dealtPoints"}, dealtPoints, 0);
    check({tag, "_deckReady"}, deckReady, 0);
    check({tag, "_deckEmpty"}, deckEmpty, 0);
    check({tag, "_cardCount"}, cardCount, 0);
    check({tag, "_loadErr"}, loadErr, 0);
  endtask

  initial begin
    int cnt[N];
    int distinct, budget;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b1;
    chk_en = 1;

    // In-order load
    for (int i = 0; i < N; i++) begin
      step(1, i, 0, 0);
      check("load_count", cardCount, i + 1);
    end
    check("load_ready", deckReady, 1);
    check("load_err0", loadErr, 0);

    // Back-to-back deal of the in-order deck
    for (int i = 0; i < N; i++) begin
      step(0, 0, 0, 1);
      check("deal_valid", dealValid, 1);
      check("deal_card", dealtCard, i);
      if (i == 0)  begin check("c0_rank", dealtRank, 1);   check("c0_pts", dealtPoints, 1);   end
      if (i == 12) begin check("c12_rank", dealtRank, 13); check("c12_pts", dealtPoints, 10); end
      if (i == 22) begin check("c22_rank", dealtRank, 10); check("c22_pts", dealtPoints, 10); end
      if (i == 51) begin check("c51_rank", dealtRank, 13); check("c51_pts", dealtPoints, 10); end
    end
    check("last_empty", deckEmpty, 1);
    check("last_ready", deckReady, 0);
    check("last_count", cardCount, 0);
    step(0, 0, 0, 1);
    check("empty_nodeal", dealValid, 0);

    // Duplicate / out-of-range rejection
    step(0, 0, 1, 0);
    step(1, 5, 0, 0);
    step(1, 5, 0, 0);
    step(1, 60, 0, 0);
    step(1, 7, 0, 0);
    check("dup_count", cardCount, 2);
    check("dup_err", loadErr, 1);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    check("dup_err_sticky", loadErr, 1);

    // newDeck beats a concurrent dealReq
    step(0, 0, 1, 0);
    load_perm(0);
    repeat (3) step(0, 0, 0, 1);
    step(0, 0, 1, 1);
    check("nd_valid", dealValid, 0);
    check("nd_count", cardCount, 0);
    check("nd_empty", deckEmpty, 0);
    check("nd_err", loadErr, 0);
    check("nd_ready", deckReady, 0);
    step(1, 33, 0, 0);
    check("nd_reload", cardCount, 1);

    // Async reset mid-deal
    step(0, 0, 1, 0);
    load_perm(1);
    repeat (20) step(0, 0, 0, 1);
    rst = 1'b0;
    m_reset();
    #1;
    check_all_zero("arst");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    step(1, 9, 0, 0);
    check("arst_reload", cardCount, 1);

    // Shuffled stream with gaps, then a full deal must cover every code once
    step(0, 0, 1, 0);
    load_perm(3);
    budget = 200;
    while (!deckReady && budget > 0) begin
      step(0, 0, 0, 0);
      budget--;
    end
    check("shuf_ready", deckReady, 1);
    foreach (cnt[i]) cnt[i] = 0;
    for (int i = 0; i < N; i++) begin
      step(0, 0, 0, 1);
      if (dealValid && dealtCard < N) cnt[dealtCard]++;
    end
    distinct = 0;
    foreach (cnt[i]) if (cnt[i] == 1) distinct++;
    check("shuf_distinct", distinct, N);
    check("shuf_err", loadErr, 0);
    check("shuf_empty", deckEmpty, 1);

    // Random traffic
    for (int k = 0; k < 4000; k++)
      step($urandom % 2, int'($urandom % 64), ($urandom % 400) == 0, $urandom % 2);

    step(0, 0, 0, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/deck_dealer.md
# deck_dealer

Downstream stage of `shuffle`: captures the stream of shuffled card codes that `shuffle` emits on `loadFlag`/`card` into a 52-entry deck store, then deals them one at a time to the blackjack game controller on request. It also checks the incoming stream for out-of-range and duplicate codes. It decodes each dealt card into rank and blackjack point value.

## Interface
- `DECK_SIZE`, 52, number of unique cards in a full deck.
- `CARD_W`, 6, card code width; valid codes are 0..DECK_SIZE-1, with rank = code % 13.
- `clk` in 1: single system clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `loadFlag` in 1: qualifies `card` for one cycle (driven by `shuffle`).
- `card` in CARD_W: shuffled card code from `shuffle`.
- `newDeck` in 1: synchronous clear; discards the deck and restarts loading.
- `dealReq` in 1: request one card; sampled every cycle.
- `dealtCard` out CARD_W: code of the last dealt card.
- `dealtRank` out 4: rank 1..13 (1 = ace, 11..13 = J/Q/K) of the last dealt card.
- `dealtPoints` out 4: blackjack value; ace = 1 (soft-ace handling belongs to the controller), 2..9 face value, 10/J/Q/K = 10.
- `dealValid` out 1: one-cycle pulse; the `dealt*` outputs are new this cycle.
- `deckReady` out 1: deck fully loaded and at least one card remains.
- `deckEmpty` out 1: all DECK_SIZE cards have been dealt.
- `cardCount` out 6: cards held = wrPtr − rdPtr (loaded so far while LOAD; remaining while READY).
- `loadErr` out 1: sticky; an invalid or duplicate code was rejected since the last clear.

## Operation
- Storage:
  - DECK_SIZE × CARD_W register array.
  - 6-bit `wrPtr` and `rdPtr`.
  - DECK_SIZE-bit `seen` mask.
- States: LOAD, READY, EMPTY. Reset and `newDeck` both go to LOAD.
- LOAD, when `loadFlag`=1:
  - If `card` < DECK_SIZE and `seen[card]`=0: write `mem[wrPtr]`, set `seen[card]`, increment `wrPtr`.
  - Otherwise: drop the code and set `loadErr`.
  - When the accepted write brings `wrPtr` to DECK_SIZE, go to READY.
- READY, when `dealReq`=1:
  - Register `mem[rdPtr]` into `dealtCard`, update rank/points, pulse `dealValid`, increment `rdPtr`.
  - When `rdPtr` reaches DECK_SIZE, go to EMPTY.
- EMPTY: hold until `newDeck`.
- Ignored inputs (no error, no state change):
  - `loadFlag` outside LOAD.
  - `dealReq` outside READY.
- `newDeck` has priority over everything else in the same cycle:
  - Clears `wrPtr`, `rdPtr`, `seen`, `loadErr`, `deckEmpty`, `deckReady`.
  - The concurrent `loadFlag` or `dealReq` is discarded.
  - The `dealt*` outputs keep their last values; `dealValid`=0.
- Rank/points come from a combinational `% 13` decode of the code being dealt, registered with `dealtCard`. Subtract-by-13 or a lookup are both acceptable.

## Timing
- Reset values: all outputs 0, state LOAD, pointers 0, `seen` 0.
- Load:
  - A card presented with `loadFlag` at edge N is counted in `cardCount` after edge N.
  - `deckReady` goes high after the edge that accepts the 52nd unique card.
- Deal latency is 1 cycle: `dealReq` sampled high at edge N gives `dealValid`=1 with new `dealtCard`/`dealtRank`/`dealtPoints` after edge N, for exactly one cycle.
- Holding `dealReq` high deals one card per cycle, back-to-back, with no bubbles.
- `deckReady` and `cardCount` update on the same edge as the deal.
- Last card: the edge that deals card 52 also drops `deckReady`, raises `deckEmpty`, and sets `cardCount`=0.
- Asynchronous reset mid-load or mid-deal: outputs go to reset values immediately. The deck contents are don't-care afterwards and must be reloaded.

## Test plan
- Reset, then load codes 0..51 in order, one per cycle → `cardCount` steps 1..52; `deckReady`=1 after the 52nd; `loadErr`=0.
- Deal 52 with `dealReq` held high → 52 consecutive `dealValid` pulses.
  - Card 0 → rank 1, points 1.
  - Card 12 → rank 13, points 10.
  - Card 22 → rank 10, points 10.
  - Card 51 → rank 13, points 10.
  - `deckEmpty`=1 after the last; a further `dealReq` gives no pulse.
- Load stream 5, 5, 60, 7 → only 5 and 7 accepted; `cardCount`=2; `loadErr`=1 stays set.
- Full deck, deal 3, assert `newDeck` together with `dealReq` → no `dealValid`; state LOAD; `cardCount`=0; `deckEmpty`=0; `loadErr`=0.
- Drive `rst` low for 1 cycle midway through dealing (20 dealt) → all outputs 0 immediately; after release, loading restarts from `wrPtr`=0.
- Connect the `shuffle` block with SEED 6'b101011 and a `shuffleFlag` pulse → `deckReady` asserts; 52 deals yield each code 0..51 exactly once; `loadErr`=0.
